state_serializer: RTL



---
 rtl/state_serializer.sv | 78 +++++++
 1 files changed

// File: rtl/state_serializer.sv
// Captures a SIZE-bit block in one cycle and streams it MSB word first as BUS-bit words.
// Word 0 is valid the cycle after load; dout_ready low stalls, data_in_ready is low while a block is in flight.
module state_serializer #(
  parameter int SIZE = 128,
  parameter int BUS  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] data_in,
  input  logic            data_in_valid,
  output logic            data_in_ready,
  output logic [BUS-1:0]  dout,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic            dout_last,
  output logic            busy
);

  localparam int WORDS = SIZE / BUS;
  localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [SIZE-1:0] sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            cnt_last;

  assign cnt_last = (cnt_q == CW'(WORDS - 1));

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (data_in_valid) begin
          sr_d    = data_in;
          cnt_d   = '0;
          state_d = ST_SEND;
        end
      end
      default: begin
        if (dout_ready) begin
          if (cnt_last) begin
            // Clear at block end so no share data lingers in the register.
            sr_d    = '0;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            sr_d  = sr_q << BUS;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout          = sr_q[SIZE-1 -: BUS];
  assign dout_valid    = (state_q == ST_SEND);
  assign busy          = dout_valid;
  assign data_in_ready = (state_q == ST_IDLE);
  assign dout_last     = dout_valid && cnt_last;

endmodule
